// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// response error codes and the request legality check.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_e;

    // Illegal codes have no defined width, so they take precedence over alignment.
    function automatic lsu_err_e check_request(input logic we, input logic [2:0] funct3,
                                               input logic [1:0] off);
        logic illegal;
        logic misaligned;
        if (we)
            illegal = (funct3 > F3_SW);
        else
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                     ((funct3[1:0] == 2'b10) && (off != 2'b00));
        if (illegal)
            return ERR_ILLEGAL;
        else if (misaligned)
            return ERR_MISALIGN;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering for the load/store unit: store byte enables and replicated
// write data, plus load lane selection with sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be   = 4'b1111;
        st_data = st_wdata;
        case (st_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << st_off;
                st_data = {4{st_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << {st_off[1], 1'b0};
                st_data = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = st_wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[8*ld_off +: 8];
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts one request at a time, issues it on the
// req/gnt/rvalid memory port and returns a single-cycle response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_wb,
    output logic [1:0]  resp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e state;
    lsu_err_e   err_next;
    logic       we_q;
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic [4:0] rd_q;
    logic [7:0] timer;
    logic [3:0] be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    assign err_next = check_request(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .st_funct3 (req_funct3),
        .st_off    (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_be     (be_next),
        .st_data   (wdata_next),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .ld_rdata  (mem_rdata),
        .ld_data   (load_data)
    );

    // Response outputs default low so they only ever pulse for the DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_wb    <= 1'b0;
            resp_err   <= ERR_OK;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            timer      <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_wb    <= 1'b0;
            resp_err   <= ERR_OK;
            case (state)
                ST_IDLE: begin
                    if (req_ready && req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        off_q     <= req_addr[1:0];
                        rd_q      <= req_rd;
                        if (err_next != ERR_OK) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= err_next;
                            resp_rd    <= req_rd;
                        end else begin
                            state     <= ST_ISSUE;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= be_next;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_we ? wdata_next : 32'd0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (we_q) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_rd    <= rd_q;
                        end else begin
                            state <= ST_WAIT;
                            timer <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state      <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        resp_rd    <= rd_q;
                        resp_wb    <= (rd_q != 5'd0);
                    end else if (timer == TIMEOUT_LAST) begin
                        state      <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_rd    <= rd_q;
                        resp_err   <= ERR_TIMEOUT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// requests compared against an arithmetic reference model.
module tb_load_store_unit;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_wb;
    logic [1:0]  resp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int tests_run;
    int tests_failed;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_wb    (resp_wb),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"},
                    {48'd0, req_ready, resp_valid, resp_wb, resp_err, resp_rd, mem_req, mem_we, mem_be},
                    64'd0);
        checkOutput({tag, "_resp_rdata"}, {32'd0, resp_rdata}, 64'd0);
        checkOutput({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
        checkOutput({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    endtask

    // One full transaction; called at a negedge, returns at a negedge.
    // rv_delay counts cycles after the grant cycle; negative means never.
    task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input int gnt_delay, input int rv_delay, input logic [31:0] rdata);
        bit          illegal, misal, timed_out, done, saw_req;
        int          size, off, exp_lat, cyc, n, gnt_wait, gnt_cyc;
        logic [1:0]  exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, mask, val, exp_rdata;
        logic        exp_wb;

        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        size    = 1 << f3[1:0];
        off     = int'(addr % 4);
        misal   = !illegal && ((addr % size) != 0);
        exp_err = illegal ? 2'b10 : (misal ? 2'b01 : 2'b00);
        timed_out = !we && exp_err == 2'b00 && (rv_delay < 0 || rv_delay > TIMEOUT);
        if (timed_out) exp_err = 2'b11;
        exp_be = 4'(((1 << size) - 1) << off);
        if (!we)            exp_wdata = 32'd0;
        else if (size == 1) exp_wdata = {24'd0, wdata[7:0]} * 32'h01010101;
        else if (size == 2) exp_wdata = {16'd0, wdata[15:0]} * 32'h00010001;
        else                exp_wdata = wdata;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        val  = (rdata >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
        exp_rdata = (!we && exp_err == 2'b00) ? val : 32'd0;
        exp_wb    = !we && exp_err == 2'b00 && rd != 5'd0;
        if (exp_err == 2'b01 || exp_err == 2'b10) exp_lat = 1;
        else if (we)                              exp_lat = 2 + gnt_delay;
        else if (timed_out)                       exp_lat = 2 + gnt_delay + TIMEOUT;
        else                                      exp_lat = 2 + gnt_delay + rv_delay;

        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;

        cyc = 1; done = 0; saw_req = 0; gnt_wait = 0; gnt_cyc = -1;
        while (!done && cyc <= 40) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = rdata;
            if (mem_req) begin
                saw_req = 1;
                checkOutput("mem_addr", {32'd0, mem_addr}, {32'd0, addr & 32'hFFFF_FFFC});
                checkOutput("mem_be", {60'd0, mem_be}, {60'd0, exp_be});
                checkOutput("mem_we", {63'd0, mem_we}, {63'd0, we});
                checkOutput("mem_wdata", {32'd0, mem_wdata}, {32'd0, exp_wdata});
                if (gnt_wait == gnt_delay) begin
                    mem_gnt = 1'b1;
                    gnt_cyc = cyc;
                end
                gnt_wait++;
            end
            if (gnt_cyc >= 0 && rv_delay >= 0 && cyc == gnt_cyc + rv_delay) mem_rvalid = 1'b1;
            if (resp_valid) begin
                done = 1;
                checkOutput("latency", 64'(cyc), 64'(exp_lat));
                checkOutput("resp_err", {62'd0, resp_err}, {62'd0, exp_err});
                checkOutput("resp_rdata", {32'd0, resp_rdata}, {32'd0, exp_rdata});
                checkOutput("resp_wb", {63'd0, resp_wb}, {63'd0, exp_wb});
                checkOutput("resp_rd", {59'd0, resp_rd}, {59'd0, rd});
            end
            @(negedge clk);
            cyc++;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        checkOutput("resp_seen", {63'd0, done}, 64'd1);
        checkOutput("mem_req_seen", {63'd0, saw_req}, {63'd0, (exp_err == 2'b00 || exp_err == 2'b11)});
        checkOutput("resp_pulse_end", {63'd0, resp_valid}, 64'd0);
        checkOutput("req_ready_after", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit any_resp;
        tests_run = 0; tests_failed = 0;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0; req_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd3, 0, 1, 32'd0);
        applyStimulus(1'b0, 3'b000, 32'h0000_2001, 32'd0, 5'd5, 0, 1, 32'h0000_F000);
        applyStimulus(1'b0, 3'b100, 32'h0000_2001, 32'd0, 5'd5, 0, 1, 32'h0000_F000);
        applyStimulus(1'b0, 3'b010, 32'h0000_2002, 32'd0, 5'd7, 0, 1, 32'd0);
        applyStimulus(1'b0, 3'b011, 32'h0000_2000, 32'd0, 5'd7, 0, 1, 32'd0);
        applyStimulus(1'b1, 3'b011, 32'h0000_2000, 32'd0, 5'd7, 0, 1, 32'd0);
        applyStimulus(1'b0, 3'b001, 32'h0000_3002, 32'd0, 5'd9, 4, 1, 32'h8001_0000);
        applyStimulus(1'b0, 3'b101, 32'h0000_3001, 32'd0, 5'd9, 0, 1, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd4, 0, -1, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 3'b010, 32'h0000_4004, 32'd0, 5'd4, 1, TIMEOUT, 32'h1234_5678);
        applyStimulus(1'b0, 3'b010, 32'h0000_4008, 32'd0, 5'd0, 0, 2, 32'hCAFE_F00D);
        applyStimulus(1'b1, 3'b001, 32'h0000_500E, 32'h0000_BEEF, 5'd1, 2, 1, 32'd0);
        applyStimulus(1'b1, 3'b010, 32'h0000_5010, 32'h1234_5678, 5'd2, 0, 1, 32'd0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                          $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                          $urandom_range(1, TIMEOUT + 2), $urandom);
        end

        // Reset while waiting for read data: no response, late rvalid ignored.
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_6000; req_rd = 5'd6;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("issue_before_reset", {63'd0, mem_req}, 64'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2 rst = 1'b0;
        #1 checkAllZero("reset_in_wait");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", {63'd0, req_ready}, 64'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        any_resp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (resp_valid) any_resp = 1;
        end
        checkOutput("no_resp_after_reset", {63'd0, any_resp}, 64'd0);

        // Reset while the memory request is outstanding drops mem_req at once.
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_7000; req_wdata = 32'hA5A5_5A5A;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("issue_store", {63'd0, mem_req}, 64'd1);
        #2 rst = 1'b0;
        #1 checkAllZero("reset_in_issue");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'h0000_7003, 32'd0, 5'd8, 0, 1, 32'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage downstream of execute: consumes the ALU-computed effective address plus store data, drives the data-memory port, returns aligned, sign/zero-extended load data to writeback.
- Handles all RV32I widths (LB/LH/LW/LBU/LHU/SB/SH/SW), byte-enable generation, misalignment detection and a memory-response timeout.
- Replaces the fixed-delay d_load/wen pulses with a valid/ready request side and a req/gnt/rvalid memory side.

Parameters:
- TIMEOUT_CYCLES, 255, WAIT-state cycles without mem_rvalid before the load is aborted with a timeout error; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  32  effective byte address.
- req_wdata  in  32  store data (rs2).
- req_rd  in  5  load destination register.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_rd  out  5  echoed req_rd.
- resp_wb  out  1  writeback required: successful load with rd != 0.
- resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  raw read word.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; every output 0, including req_ready. A reset mid-operation aborts the access, drops mem_req at once and produces no response. An mem_rvalid arriving later is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On req_valid, latch all request fields.
  - Error checks first. Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Illegal: load funct3 011/110/111, store funct3 >010.
  - Error -> DONE with the matching err; no memory access. Otherwise -> ISSUE.
- ISSUE: mem_req=1; mem_addr/mem_we/mem_be/mem_wdata held stable until mem_gnt.
  - Store with gnt -> DONE.
  - Load with gnt -> WAIT and clear the timeout counter.
- WAIT: mem_rvalid is sampled only in this state. mem_rvalid -> capture extended data -> DONE.
  - Counter increments each cycle; when it reaches TIMEOUT_CYCLES without rvalid -> DONE, err=11, rdata=0.
- DONE: resp_valid=1 for exactly one cycle -> IDLE. Back-to-back requests are accepted on the following cycle.
- Latency from accept edge:
  - Store with immediate gnt: resp_valid 2 cycles later.
  - Load with immediate gnt and rvalid one cycle after gnt: 3 cycles.
  - Error: 1 cycle.
- Store lanes, off = addr[1:0]:
  - SB: wdata={4{b}}, be=0001<<off.
  - SH: wdata={2{h}}, be=0011<<(2*addr[1]).
  - SW: be=1111.
- Load extraction:
  - LB/LBU: byte at lane off, sign- or zero-extended.
  - LH/LHU: half at lane addr[1], sign- or zero-extended.
  - LW: full word.
- resp_wb=0 for stores, errors and rd=0.

Decomposition:
- Shared header consts.h gains: funct3 codes (LB..SW), state encodings, resp_err codes.
- Sub-module lsu_align: combinational; store be/wdata generation plus load lane-select and extension.
- load_store_unit: FSM, request latch, timeout counter.

Test Plan:
- SB addr=0x1003 wdata=0x000000A5, gnt immediate -> mem_addr=0x1000, be=1000, mem_wdata=0xA5A5A5A5, resp_valid 2 cycles after accept, err=00.
- LB addr=0x2001, mem_rdata=0x0000F000, rd=5 -> resp_rdata=0xFFFFFFF0, resp_wb=1, resp_rd=5. Same request with LBU -> 0x000000F0.
- LW addr=0x2002 -> resp_valid next cycle, err=01, mem_req never asserted. Load funct3=011 -> err=10.
- LH addr=0x3002, gnt withheld 4 cycles -> mem_req and all mem_* outputs stable throughout. rvalid with rdata=0x80010000 -> rdata=0xFFFF8001.
- TIMEOUT_CYCLES=8, LW with no rvalid -> resp_valid after 8 WAIT cycles, err=11, rdata=0, resp_wb=0.
- rst low while in WAIT, then rvalid pulses after release -> no resp_valid, all outputs 0, req_ready=1 on the first cycle after rst rises.
